fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised synchronous FIFO; the next-generation buffer block for datapaths that need more than a fixed 8×1-bit queue. Configurable data width and depth, with an occupancy count, programmable almost-full/almost-empty thresholds, push-while-full when a pop occurs in the same cycle, a synchronous flush, and sticky overflow/underflow error flags. Sits between a producer and a consumer in one clock domain, with a show-ahead read port: the head word is always visible on `data_out`.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries, ≥2; need not be a power of two.
- `AFULL_TH`, DEPTH-2: `almost_full` asserts when count ≥ AFULL_TH.
- `AEMPTY_TH`, 2: `almost_empty` asserts when count ≤ AEMPTY_TH.
- CW (localparam) = $clog2(DEPTH+1); PW (localparam) = max(1, $clog2(DEPTH)).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `push` in 1: write request.
- `data_in` in WIDTH: write data.
- `pop` in 1: read request; consumes the head word.
- `flush` in 1: synchronous empty, which discards all contents.
- `err_clr` in 1: clears the sticky error flags.
- `data_out` out WIDTH: head word, show-ahead.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AFULL_TH.
- `almost_empty` out 1: count ≤ AEMPTY_TH.
- `count` out CW: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when a push is rejected.
- `underflow` out 1: sticky; set when a pop is rejected.

## Operation
- Storage is DEPTH × WIDTH registers. Write pointer `wr_ptr` and read pointer `rd_ptr` are PW bits wide. Each pointer increments on acceptance and wraps from DEPTH-1 to 0, with explicit compare (not modulo 2^PW).
- `pop_en` = pop & !empty.
- `push_en` = push & (!full | pop_en). When full, a push is accepted only if a pop is also accepted in the same cycle.
- No bypass on empty: push and pop together while empty gives the push accepted and the pop rejected (underflow is set).
- `count` update: +1 on push_en only, −1 on pop_en only, unchanged when both or neither occur. Count never leaves 0..DEPTH.
- `data_out` = mem[rd_ptr], combinational from registered state.
- Status flags `full`, `empty`, `almost_full` and `almost_empty` decode combinationally from the registered `count`.
- Errors:
  - `overflow` is set on push & !push_en.
  - `underflow` is set on pop & !pop_en.
  - Both hold until `err_clr` or `rst`.
  - If a set and `err_clr` occur in the same cycle, set wins.
- Flush: on the next edge, pointers and count go to 0. Memory contents are not cleared. Push and pop in the flush cycle are ignored and do not set the error flags.
- Priority: rst > flush > push/pop.
- Reset values:
  - Pointers, count, overflow and underflow are 0.
  - Memory is all 0.
  - Therefore after reset `data_out`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0 (for AFULL_TH ≥ 1).
- Reset mid-operation discards all contents; no outstanding state survives.

## Timing
- All state updates on the rising `clk` edge. No combinational path from `push` or `pop` to any status output. `data_out` depends only on registered state.
- Write-to-read latency is 1 cycle. A word pushed at edge k into an empty FIFO appears on `data_out`, with `empty`=0, after edge k.
- A pop at edge k advances `data_out` to the next word after edge k.
- Flags and `count` reflect all push/pop/flush activity of edge k from cycle k+1.
- Sustained throughput is one push plus one pop per cycle at any occupancy, including full.

## Test plan
- Reset, then fill and drain (DEPTH=16, WIDTH=8):
  - Push 0x00..0x0F on 16 consecutive cycles. Expect `full`=1, `count`=16, `almost_full` from count 14.
  - Pop 16 times. Expect `data_out` sequence 0x00..0x0F, `empty`=1, no error flags.
- Wrap-around with DEPTH=5:
  - Push 3, pop 3, then push 5 values 0xA0..0xA4.
  - Expect `full`=1 and readback order 0xA0..0xA4, proving the pointer wraps at 4→0.
- Full, push+pop in the same cycle:
  - At count=16, push 0x55 with pop. Expect count to stay 16, `overflow`=0, old head returned.
  - Then drain. Expect 0x55 last.
- Error flags:
  - Push when full without pop. Expect `overflow`=1 and count unchanged.
  - Pop when empty. Expect `underflow`=1.
  - Push+pop on empty. Expect count=1 and `underflow`=1.
  - Assert `err_clr` together with a new overflow. Expect `overflow` to stay 1.
  - `err_clr` alone clears both flags.
- Flush and reset mid-stream:
  - At count=7, assert flush together with push. Expect count=0 and `empty`=1 next cycle, and no overflow.
  - Refill 3 words, then assert `rst`. Expect all outputs at their reset values next cycle and `data_out`=0.
- Random push/pop for 10k cycles against a reference queue model. Expect data order, `count`, every flag and the sticky errors to match each cycle.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with show-ahead read port, occupancy count,
// almost-full/almost-empty thresholds, flush and sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        push_en, pop_en;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full         = (int'(count) == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AFULL_TH);
  assign almost_empty = (int'(count) <= AEMPTY_TH);
  assign data_out     = mem[rd_ptr];

  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      // Contents are abandoned in place; push/pop this cycle are ignored.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= overflow & ~err_clr;
      underflow <= underflow & ~err_clr;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop_en) rd_ptr <= nxt(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error in the same cycle as err_clr keeps the flag set.
      overflow  <= (push & ~push_en) | (overflow & ~err_clr);
      underflow <= (pop & ~pop_en) | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: directed scenarios plus a queue-model scoreboard
// that checks status every cycle and the head word on every accepted pop.
module tb_fifo_sync_param;
  localparam int D = 16;

  logic       clk = 1'b0, rst = 1'b1;
  logic       push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       push5 = 1'b0, pop5 = 1'b0, zero5 = 1'b0;
  logic [7:0] din5 = '0, data_out5;
  logic       full5, empty5, afull5, aempty5, ovf5, unf5;
  logic [2:0] count5;

  int errs = 0, checks = 0;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(din), .pop(pop), .flush(flush),
    .err_clr(err_clr), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  fifo_sync_param #(.WIDTH(8), .DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(1)) dut5 (
    .clk(clk), .rst(rst), .push(push5), .data_in(din5), .pop(pop5), .flush(zero5),
    .err_clr(zero5), .data_out(data_out5), .full(full5), .empty(empty5),
    .almost_full(afull5), .almost_empty(aempty5), .count(count5),
    .overflow(ovf5), .underflow(unf5));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard for the 16-deep instance.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0, m_unf = 1'b0;

  always @(negedge clk) begin
    bit pe, we;
    chk("count", 32'(count), q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= D - 2));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush) begin
      q.delete();
      if (err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      pe = pop && (q.size() > 0);
      we = push && ((q.size() < D) || pe);
      if (pe) begin
        chk("sb_data_out", 32'(data_out), 32'(q[0]));
        void'(q.pop_front());
      end
      if (we) q.push_back(din);
      m_ovf = (push && !we) || (m_ovf && !err_clr);
      m_unf = (pop && !pe) || (m_unf && !err_clr);
    end
  end

  task automatic cyc(input bit p, input bit r, input logic [7:0] d,
                     input bit f = 1'b0, input bit c = 1'b0);
    push = p; pop = r; din = d; flush = f; err_clr = c;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic cyc5(input bit p, input bit r, input logic [7:0] d);
    push5 = p; pop5 = r; din5 = d;
    @(posedge clk); #1;
    push5 = 1'b0; pop5 = 1'b0;
  endtask

  initial begin
    logic [7:0] exp8;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_data_out", 32'(data_out), 0);

    // Fill and drain
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_head", 32'(data_out), i);
      cyc(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf", 32'(overflow), 0);
    chk("drain_unf", 32'(underflow), 0);

    // Wrap-around on the 5-deep instance
    for (int i = 0; i < 3; i++) cyc5(1'b1, 1'b0, 8'(i + 1));
    for (int i = 0; i < 3; i++) cyc5(1'b0, 1'b1, 8'h00);
    chk("w5_empty", 32'(empty5), 1);
    for (int i = 0; i < 5; i++) cyc5(1'b1, 1'b0, 8'hA0 + 8'(i));
    chk("w5_full", 32'(full5), 1);
    chk("w5_count", 32'(count5), 5);
    for (int i = 0; i < 5; i++) begin
      chk("w5_head", 32'(data_out5), 32'h A0 + i);
      cyc5(1'b0, 1'b1, 8'h00);
    end
    chk("w5_empty_end", 32'(empty5), 1);
    chk("w5_no_err", 32'({ovf5, unf5}), 0);

    // Push + pop while full
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i));
    chk("pp_head", 32'(data_out), 32'h10);
    cyc(1'b1, 1'b1, 8'h55);
    chk("pp_count", 32'(count), 16);
    chk("pp_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      exp8 = (i < 15) ? 8'h11 + 8'(i) : 8'h55;
      chk("pp_drain", 32'(data_out), 32'(exp8));
      cyc(1'b0, 1'b1, 8'h00);
    end

    // Error flags
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h30 + 8'(i));
    cyc(1'b1, 1'b0, 8'hEE);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("flush_keeps_ovf", 32'(overflow), 1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("unf_set", 32'(underflow), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_unf", 32'(underflow), 0);
    cyc(1'b1, 1'b1, 8'h61);
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_unf", 32'(underflow), 1);
    chk("pp_empty_head", 32'(data_out), 32'h61);
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 8'h62 + 8'(i));
    cyc(1'b1, 1'b0, 8'hEF, 1'b0, 1'b1);
    chk("set_wins_ovf", 32'(overflow), 1);
    chk("set_wins_unf_cleared", 32'(underflow), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_alone", 32'({overflow, underflow}), 0);

    // Flush with push, then reset mid-stream
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i));
    chk("pre_flush_count", 32'(count), 7);
    cyc(1'b1, 1'b0, 8'h99, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h77 + 8'(i));
    chk("refill_head", 32'(data_out), 32'h77);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_outs", 32'({full, empty, almost_full, almost_empty, overflow, underflow}), 32'b010100);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_data_out", 32'(data_out), 0);

    // Random traffic against the model
    for (int n = 0; n < 10000; n++) begin
      int ph;
      bit f, c;
      ph = (n / 700) % 3;
      f = ($urandom_range(0, 99) == 0);
      c = !f && ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      cyc($urandom_range(0, 99) < (ph == 0 ? 75 : ph == 1 ? 50 : 25),
          $urandom_range(0, 99) < (ph == 0 ? 25 : ph == 1 ? 50 : 75),
          8'($urandom_range(0, 255)), f, c);
      rst = 1'b0;
    end
    @(negedge clk);
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
